// File: rtl/ck_pkg.sv
// ck_pkg -- shared definitions for the fractional clock-enable divider.
//   ST_IDLE / ST_SETTLE / ST_LOCKED : lock state encoding
//   settle_cnt_width()              : width of the saturating settle counter
package ck_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // ceil(log2(lock_cycles + 1)), never less than one bit.
  function automatic int settle_cnt_width(input int lock_cycles);
    int w;
    w = 1;
    while ((1 << w) < (lock_cycles + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ck_frac_div_if.sv
// ck_frac_div_if -- configuration and status bundle for ck_frac_div.
//   cfg_we / cfg_mult / cfg_div : configuration write strobe and ratio M/D
//   cfg_busy                    : captured config not yet applied
//   ce / ck_out                 : clock-enable pulse and divided square wave
//   locked / err                : rate settled / active config invalid
// master drives configuration, slave is the divider side.
interface ck_frac_div_if #(
  parameter int WIDTH = 16
) ();
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_mult;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_busy;
  logic             ce;
  logic             ck_out;
  logic             locked;
  logic             err;

  modport master (
    output cfg_we, cfg_mult, cfg_div,
    input  cfg_busy, ce, ck_out, locked, err
  );

  modport slave (
    input  cfg_we, cfg_mult, cfg_div,
    output cfg_busy, ce, ck_out, locked, err
  );
endinterface

// File: rtl/ck_phase_acc.sv
// ck_phase_acc -- phase accumulator and wrap compare.
//   clk, rst_n : clock and asynchronous active-low reset
//   run        : advance the accumulator by mult this cycle
//   clear      : load zero (takes priority over run)
//   mult, div  : active ratio terms, mult <= div guaranteed while running
//   wrap       : combinational, sum >= div this cycle
//   acc        : accumulator value, always < div while running
module ck_phase_acc
  import ck_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clear,
  input  logic [WIDTH-1:0] mult,
  input  logic [WIDTH-1:0] div,
  output logic             wrap,
  output logic [WIDTH:0]   acc
);

  logic [WIDTH:0] acc_reg;
  logic [WIDTH:0] acc_next;
  logic [WIDTH:0] sum;

  // One extra bit holds acc + mult without overflow since acc < div and mult <= div.
  always_comb begin
    sum      = acc_reg + {1'b0, mult};
    wrap     = run && (sum >= {1'b0, div});
    acc_next = acc_reg;
    if (clear) begin
      acc_next = '0;
    end else if (wrap) begin
      acc_next = sum - {1'b0, div};
    end else if (run) begin
      acc_next = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/ck_frac_div.sv
// ck_frac_div -- fractional clock-enable generator, ce rate f*M/D.
//   ck_in, sys_rst_i        : clock, asynchronous active-low reset
//   cfg_we_i, cfg_mult_i/div: config write (captured into shadow registers)
//   cfg_busy_o              : shadow config pending
//   ce_o, ck_out            : registered enable pulse and toggle output
//   locked_o, err_o         : rate settled / active config invalid
// A pending config is applied only on an accumulator wrap (or at once when
// idle) so the period in progress always completes.
module ck_frac_div
  import ck_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int MULT_BY     = 1,
  parameter int DIV_BY      = 1,
  parameter int LOCK_CYCLES = 4
) (
  input  logic             ck_in,
  input  logic             sys_rst_i,
  input  logic             cfg_we_i,
  input  logic [WIDTH-1:0] cfg_mult_i,
  input  logic [WIDTH-1:0] cfg_div_i,
  output logic             cfg_busy_o,
  output logic             ce_o,
  output logic             ck_out,
  output logic             locked_o,
  output logic             err_o
);

  localparam int              CNT_W   = settle_cnt_width(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYCLES);

  logic [WIDTH-1:0] mult_reg, div_reg, shd_mult_reg, shd_div_reg;
  logic [WIDTH-1:0] mult_next, div_next;
  logic             busy_reg, busy_next;
  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             skip_reg, skip_next;
  logic             ce_reg, ck_reg, locked_reg, locked_next, err_reg, err_next;
  logic             idle, run, wrap, apply, cfg_bad, cfg_zero;
  logic [WIDTH:0]   acc;

  ck_phase_acc #(.WIDTH(WIDTH)) u_acc (
    .clk   (ck_in),
    .rst_n (sys_rst_i),
    .run   (run),
    .clear (apply),
    .mult  (mult_reg),
    .div   (div_reg),
    .wrap  (wrap),
    .acc   (acc)
  );

  always_comb begin
    idle        = (state_reg == ST_IDLE);
    run         = !idle;
    apply       = busy_reg && (wrap || idle);
    mult_next   = apply ? shd_mult_reg : mult_reg;
    div_next    = apply ? shd_div_reg  : div_reg;
    cfg_bad     = (div_next == '0) || (mult_next > div_next);
    cfg_zero    = (mult_next == '0);
    busy_next   = cfg_we_i ? 1'b1 : (apply ? 1'b0 : busy_reg);
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    skip_next   = 1'b0;
    locked_next = locked_reg;
    err_next    = err_reg;
    if (apply || idle) begin
      // (Re)evaluate the config that will be active next cycle.
      cnt_next  = '0;
      // The pulse of the wrap that triggered the apply belongs to the old
      // config and must not count toward settling.
      skip_next = apply && wrap;
      if (cfg_bad) begin
        state_next  = ST_IDLE;
        err_next    = 1'b1;
        locked_next = 1'b0;
      end else if (cfg_zero) begin
        state_next  = ST_IDLE;
        err_next    = 1'b0;
        locked_next = 1'b1;
      end else begin
        state_next  = ST_SETTLE;
        err_next    = 1'b0;
        locked_next = 1'b0;
      end
    end else if ((state_reg == ST_SETTLE) && ce_reg && !skip_reg) begin
      if (cnt_reg < CNT_MAX) begin
        cnt_next = cnt_reg + 1'b1;
      end
      if (cnt_next >= CNT_MAX) begin
        state_next  = ST_LOCKED;
        locked_next = 1'b1;
      end
    end
  end

  always_ff @(posedge ck_in or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      mult_reg     <= WIDTH'(MULT_BY);
      div_reg      <= WIDTH'(DIV_BY);
      shd_mult_reg <= WIDTH'(MULT_BY);
      shd_div_reg  <= WIDTH'(DIV_BY);
      busy_reg     <= 1'b0;
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      skip_reg     <= 1'b0;
      ce_reg       <= 1'b0;
      ck_reg       <= 1'b0;
      locked_reg   <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      if (cfg_we_i) begin
        shd_mult_reg <= cfg_mult_i;
        shd_div_reg  <= cfg_div_i;
      end
      mult_reg   <= mult_next;
      div_reg    <= div_next;
      busy_reg   <= busy_next;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      skip_reg   <= skip_next;
      ce_reg     <= wrap;
      ck_reg     <= ck_reg ^ wrap;
      locked_reg <= locked_next;
      err_reg    <= err_next;
    end
  end

  assign cfg_busy_o = busy_reg;
  assign ce_o       = ce_reg;
  assign ck_out     = ck_reg;
  assign locked_o   = locked_reg;
  assign err_o      = err_reg;

endmodule

// File: doc/ck_frac_div.md
CK_FRAC_DIV -- requirements
Module: ck_frac_div

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit width of the mult/div ratio terms.
REQ-002 SHALL have parameter MULT_BY, default 1: mult value loaded at reset.
REQ-003 SHALL have parameter DIV_BY, default 1: div value loaded at reset.
REQ-004 SHALL have parameter LOCK_CYCLES, default 4: number of ce_o pulses after a config apply before locked_o asserts.
REQ-005 SHALL have port ck_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port sys_rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port cfg_we_i, input, 1 bit: one-cycle strobe that captures cfg_mult_i and cfg_div_i.
REQ-008 SHALL have port cfg_mult_i, input, WIDTH bits: requested multiplier M.
REQ-009 SHALL have port cfg_div_i, input, WIDTH bits: requested divisor D.
REQ-010 SHALL have port cfg_busy_o, output, 1 bit: a captured config is pending and not yet applied.
REQ-011 SHALL have port ce_o, output, 1 bit: registered one-cycle clock-enable pulse at average rate f(ck_in)*M/D.
REQ-012 SHALL have port ck_out, output, 1 bit: registered square wave that toggles on every ce_o, so its rate is f*M/(2D).
REQ-013 SHALL have port locked_o, output, 1 bit: output rate is settled at the active config.
REQ-014 SHALL have port err_o, output, 1 bit: active config is invalid (D==0, or M>D).

Function
REQ-015 SHALL keep a phase accumulator acc of WIDTH+1 bits; each cycle in RUN it computes sum = acc + M at WIDTH+1 bits with no overflow possible, because acc < D and M <= D.
REQ-016 SHALL, when sum >= D, assert ce_o on the next cycle and load acc <= sum - D; otherwise it SHALL load acc <= sum with ce_o low.
REQ-017 SHALL drive ce_o and ck_out from flops, with ce_o rising exactly one cycle after the accumulator decision.
REQ-018 SHALL treat M==D as ce_o high every cycle, with ck_out toggling every cycle.
REQ-019 SHALL treat M==0, with D nonzero, as a valid config: state IDLE, no pulses, ck_out held, err_o=0, locked_o=1.
REQ-020 SHALL treat D==0 or M>D as invalid: state IDLE, no pulses, err_o=1, locked_o=0.
REQ-021 SHALL use a state machine with states IDLE, SETTLE and LOCKED.
REQ-022 SHALL, from IDLE, go to SETTLE when the active config is valid with M>0.
REQ-023 SHALL, in SETTLE, count ce_o pulses and go to LOCKED when the count reaches LOCK_CYCLES.
REQ-024 SHALL, from any state, go to IDLE when an invalid or M==0 config is applied.
REQ-025 SHALL assert locked_o only in LOCKED, except in the M==0 case of REQ-019.
REQ-026 SHALL, on cfg_we_i, capture M and D into shadow registers and set cfg_busy_o on the next cycle.
REQ-027 SHALL, when a second cfg_we_i arrives while busy, overwrite the shadow registers so that the last write wins.
REQ-028 SHALL apply a pending shadow config in the same cycle as the accumulator wrap (sum >= D) and load acc <= 0, so the period in progress is never truncated.
REQ-029 SHALL apply a pending shadow config on the next cycle when the state is IDLE.
REQ-030 SHALL, on apply, clear cfg_busy_o, restart the SETTLE count and drop locked_o on the following cycle.
REQ-031 SHALL, when cfg_we_i coincides with an apply, capture the new value as pending rather than losing it.
REQ-032 SHALL keep the SETTLE counter at ceil(log2(LOCK_CYCLES+1)) bits, saturating.

Reset
REQ-033 SHALL, while sys_rst_i is low, asynchronously clear acc, ce_o, ck_out, cfg_busy_o and the SETTLE counter, load M=MULT_BY and D=DIV_BY, and enter IDLE.
REQ-034 SHALL hold locked_o=0 and err_o=0 during reset.
REQ-035 SHALL, on the first cycle after reset release, evaluate the reset config per REQ-019 and REQ-020, so the default 1/1 reaches SETTLE and then LOCKED after LOCK_CYCLES+1 cycles.
REQ-036 SHALL, when reset asserts mid-period, abort the period and discard any pending config.

Structure
REQ-037 SHALL place the state encoding (IDLE, SETTLE, LOCKED) in a shared package ck_pkg, together with the helper function that sizes the SETTLE counter.
REQ-038 SHALL implement the accumulator and compare as one sub-module, ck_phase_acc; shadow config, state machine and output flops stay in ck_frac_div.

Verification
REQ-039 SHALL cover: M=1, D=1 after reset -> ce_o high every cycle; ck_out toggles every cycle; locked_o high at cycle 6 with LOCK_CYCLES=4.
REQ-040 SHALL cover: M=3, D=8 -> ce_o on cycles 3, 6 and 8 of each 8-cycle window; exactly 3 pulses per 8 cycles over 800 cycles; acc returns to 0 every 8 cycles.
REQ-041 SHALL cover: while running 3/8, write 1/2 at cycle 4 -> cfg_busy_o high until the wrap at cycle 6, then ce_o every second cycle; locked_o low for 4 pulses, then high.
REQ-042 SHALL cover: write M=5, D=4 -> err_o=1, locked_o=0, no ce_o; then write 1/4 -> err_o clears and ce_o every 4th cycle.
REQ-043 SHALL cover: two writes, 1/3 then 2/5, on consecutive cycles while busy -> only 2/5 is applied, with 2 pulses per 5 cycles.
REQ-044 SHALL cover: assert sys_rst_i low mid-period with a pending config -> all outputs 0 asynchronously; after release, MULT_BY/DIV_BY behaviour resumes and the pending config is gone.
